// File: rtl/enigma_rotor_param_if.sv
// Bundles the per-rotor control, datapath and status signals of one rotor stage.
// Latency: none (wires only).
// Backpressure: none; every signal is sampled or driven every cycle.
interface enigma_rotor_param_if #(
  parameter int N = 26,
  parameter int W = 5
);
  logic         load;
  logic [W-1:0] load_pos;
  logic [W-1:0] ring;
  logic         step_in;
  logic         key_step;
  logic [N-1:0] fwd_in;
  logic [N-1:0] fwd_out;
  logic [N-1:0] rev_in;
  logic [N-1:0] rev_out;
  logic [W-1:0] pos;
  logic         at_notch;
  logic         carry_out;
  logic         load_err;

  // Driver side: keyboard / neighbouring rotor / test stimulus.
  modport master (
    output load, load_pos, ring, step_in, key_step, fwd_in, rev_in,
    input  fwd_out, rev_out, pos, at_notch, carry_out, load_err
  );

  // Rotor side.
  modport slave (
    input  load, load_pos, ring, step_in, key_step, fwd_in, rev_in,
    output fwd_out, rev_out, pos, at_notch, carry_out, load_err
  );
endinterface

// File: rtl/enigma_rotor_param.sv
// Parametrised Enigma rotor: selectable wiring, ring offset, notch carry, double-step.
// Latency: letter paths are combinational (0 cycles); pos/load_err update on the clock edge.
// Backpressure: none; a step or load is accepted on every cycle it is presented.
module enigma_rotor_param #(
  parameter int N           = 26,
  parameter int W           = 5,
  parameter int WIRING_SEL  = 0,
  parameter int AFF_A       = 3,
  parameter int AFF_B       = 1,
  parameter int NOTCH       = 16,
  parameter int DOUBLE_STEP = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  enigma_rotor_param_if.slave   rotor
);

  localparam int W1 = W + 1;

  // Historical rotor I and II wirings, first letter in the MSB byte.
  localparam logic [8*26-1:0] ROTOR_I  = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] ROTOR_II = "AJDKSIRUXBLHWTMCQGZNPYFVOE";

  // Forward wiring: contact i on the entry side lands on contact wire_map(i).
  function automatic int wire_map(input int i);
    int         r;
    logic [7:0] ch;
    r  = i;
    ch = 8'd0;
    case (WIRING_SEL)
      0: begin
        case (i)
          0:  r = 17;  17: r = 0;
          1:  r = 20;  20: r = 1;
          2:  r = 12;  12: r = 2;
          3:  r = 23;  23: r = 3;
          4:  r = 9;   9:  r = 4;
          5:  r = 10;  10: r = 5;
          6:  r = 15;  15: r = 6;
          7:  r = 18;  18: r = 7;
          8:  r = 25;  25: r = 8;
          11: r = 24;  24: r = 11;
          13: r = 16;  16: r = 13;
          14: r = 21;  21: r = 14;
          19: r = 22;  22: r = 19;
          default: r = i;
        endcase
      end
      1: begin
        ch = ROTOR_I[8*(25-i) +: 8];
        r  = int'(ch) - 65;
      end
      2: begin
        ch = ROTOR_II[8*(25-i) +: 8];
        r  = int'(ch) - 65;
      end
      default: r = (((AFF_A * i + AFF_B) % N) + N) % N;
    endcase
    return r;
  endfunction

  // Inverse wiring found by search; only ever evaluated at elaboration.
  function automatic int inv_map(input int j);
    int r;
    r = 0;
    for (int k = 0; k < N; k++) begin
      if (wire_map(k) == j) r = k;
    end
    return r;
  endfunction

  // Rotate so that out[k] = v[(k - s) mod N]; s must be < N.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [W:0] s);
    return (v << s) | (v >> (W1'(N) - s));
  endfunction

  // Rotate so that out[k] = v[(k + s) mod N]; s must be < N.
  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input logic [W:0] s);
    return (v >> s) | (v << (W1'(N) - s));
  endfunction

  logic [W-1:0] pos_q;
  logic         load_err_q;
  logic [W:0]   ring_m;
  logic [W:0]   offset;
  logic         at_notch;
  logic         adv;
  logic         load_ok;
  logic [W-1:0] pos_inc;
  logic [N-1:0] s1f, s2f, s1r, s2r;

  // Offset between the alphabet ring and the wiring core, always kept in 0..N-1.
  always_comb begin
    ring_m = {1'b0, rotor.ring} % W1'(N);
    offset = {1'b0, pos_q} + W1'(N) - ring_m;
    if (offset >= W1'(N)) offset = offset - W1'(N);
  end

  // Entry-side rotation into the wiring core for both paths.
  always_comb begin
    s1f = rotl(rotor.fwd_in, offset);
    s1r = rotl(rotor.rev_in, offset);
  end

  // Fixed core wiring; every bit is a pure permutation so popcount is preserved.
  for (genvar c = 0; c < N; c++) begin : g_wire
    localparam int TF = wire_map(c);
    localparam int TR = inv_map(c);
    assign s2f[TF] = s1f[c];
    assign s2r[TR] = s1r[c];
  end

  // Exit-side rotation back into alphabet coordinates.
  always_comb begin
    rotor.fwd_out = rotr(s2f, offset);
    rotor.rev_out = rotr(s2r, offset);
  end

  // Stepping decode; carry is combinational so a whole chain steps on one edge.
  always_comb begin
    at_notch = (pos_q == W'(NOTCH));
    adv      = rotor.step_in | ((DOUBLE_STEP != 0) & rotor.key_step & at_notch);
    load_ok  = ({1'b0, rotor.load_pos} < W1'(N));
    pos_inc  = (pos_q == W'(N - 1)) ? '0 : pos_q + W'(1);
  end

  // Position register: load beats step; an out-of-range load flags a one-cycle error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q      <= '0;
      load_err_q <= 1'b0;
    end else if (rotor.load && load_ok) begin
      pos_q      <= rotor.load_pos;
      load_err_q <= 1'b0;
    end else if (rotor.load) begin
      load_err_q <= 1'b1;
    end else if (adv) begin
      pos_q      <= pos_inc;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
    end
  end

  // Status outputs.
  always_comb begin
    rotor.pos       = pos_q;
    rotor.at_notch  = at_notch;
    rotor.carry_out = adv & at_notch;
    rotor.load_err  = load_err_q;
  end

endmodule

// File: tb/tb_enigma_rotor_param.sv
// Directed bench for enigma_rotor_param across four configurations.
// Latency: checks combinational paths 1-2 ns after driving, registers 1 ns after the edge.
// Backpressure: not applicable.
module tb_enigma_rotor_param;

  logic clock;
  logic reset;
  int   vec_cnt;
  int   miss_cnt;

  enigma_rotor_param_if #(.N(26), .W(5)) b0 ();
  enigma_rotor_param_if #(.N(26), .W(5)) b1 ();
  enigma_rotor_param_if #(.N(26), .W(5)) b2 ();
  enigma_rotor_param_if #(.N(7),  .W(3)) b3 ();

  // Rotor I wiring
  enigma_rotor_param #(.N(26), .W(5), .WIRING_SEL(1), .NOTCH(16), .DOUBLE_STEP(0)) u_rot1 (
    .clock(clock), .reset(reset), .rotor(b0));
  // Involution wiring, no double-step
  enigma_rotor_param #(.N(26), .W(5), .WIRING_SEL(0), .NOTCH(16), .DOUBLE_STEP(0)) u_inv (
    .clock(clock), .reset(reset), .rotor(b1));
  // Involution wiring, double-step
  enigma_rotor_param #(.N(26), .W(5), .WIRING_SEL(0), .NOTCH(16), .DOUBLE_STEP(1)) u_dbl (
    .clock(clock), .reset(reset), .rotor(b2));
  // 7-letter affine wiring
  enigma_rotor_param #(.N(7), .W(3), .WIRING_SEL(3), .AFF_A(3), .AFF_B(1), .NOTCH(5),
                       .DOUBLE_STEP(0)) u_aff (
    .clock(clock), .reset(reset), .rotor(b3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    if (b0.pos !== 5'd0) begin miss_cnt++; $display("FAIL reset_pos_rot1 got %0d want 0", b0.pos); end
    vec_cnt++;
    if (b1.pos !== 5'd0) begin miss_cnt++; $display("FAIL reset_pos_inv got %0d want 0", b1.pos); end
    vec_cnt++;
    if (b3.pos !== 3'd0) begin miss_cnt++; $display("FAIL reset_pos_aff got %0d want 0", b3.pos); end
    vec_cnt++;
    if (b1.load_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_load_err got %b want 0", b1.load_err); end
    vec_cnt++;
  endtask

  task automatic test_rotor1_pos0();
    b0.ring = 5'd0;
    b0.fwd_in = 26'd1 << 0;
    b0.rev_in = 26'd1 << 4;
    #1;
    if (b0.fwd_out !== (26'd1 << 4)) begin miss_cnt++; $display("FAIL rot1_fwd_p0 got %h want %h", b0.fwd_out, 26'd1 << 4); end
    vec_cnt++;
    if (b0.rev_out !== (26'd1 << 0)) begin miss_cnt++; $display("FAIL rot1_rev_p0 got %h want %h", b0.rev_out, 26'd1); end
    vec_cnt++;
    // Z -> J, and a two-hot input keeps both letters
    b0.fwd_in = (26'd1 << 0) | (26'd1 << 25);
    #1;
    if (b0.fwd_out !== ((26'd1 << 4) | (26'd1 << 9))) begin
      miss_cnt++; $display("FAIL rot1_twohot got %h want %h", b0.fwd_out, (26'd1 << 4) | (26'd1 << 9));
    end
    vec_cnt++;
  endtask

  task automatic test_rotor1_step();
    b0.step_in = 1'b1;
    tick();
    b0.step_in = 1'b0;
    if (b0.pos !== 5'd1) begin miss_cnt++; $display("FAIL rot1_step_pos got %0d want 1", b0.pos); end
    vec_cnt++;
    b0.fwd_in = 26'd1 << 0;
    b0.rev_in = 26'd1 << 9;
    #1;
    if (b0.fwd_out !== (26'd1 << 9)) begin miss_cnt++; $display("FAIL rot1_fwd_p1 got %h want %h", b0.fwd_out, 26'd1 << 9); end
    vec_cnt++;
    if (b0.rev_out !== (26'd1 << 0)) begin miss_cnt++; $display("FAIL rot1_rev_p1 got %h want %h", b0.rev_out, 26'd1); end
    vec_cnt++;
    // ring 27 reduces to 1, cancelling pos 1: back to A -> E
    b0.ring = 5'd27;
    #1;
    if (b0.fwd_out !== (26'd1 << 4)) begin miss_cnt++; $display("FAIL rot1_ring_wrap got %h want %h", b0.fwd_out, 26'd1 << 4); end
    vec_cnt++;
    b0.ring = 5'd0;
  endtask

  task automatic test_involution();
    b1.fwd_in = 26'd1 << 0;
    b1.rev_in = 26'd1 << 17;
    #1;
    if (b1.fwd_out !== (26'd1 << 17)) begin miss_cnt++; $display("FAIL inv_fwd got %h want %h", b1.fwd_out, 26'd1 << 17); end
    vec_cnt++;
    if (b1.rev_out !== (26'd1 << 0)) begin miss_cnt++; $display("FAIL inv_rev got %h want %h", b1.rev_out, 26'd1); end
    vec_cnt++;
    b1.fwd_in = '0;
    #1;
    if (b1.fwd_out !== 26'd0) begin miss_cnt++; $display("FAIL inv_zero got %h want 0", b1.fwd_out); end
    vec_cnt++;
  endtask

  task automatic test_notch_carry();
    b1.load = 1'b1;
    b1.load_pos = 5'd16;
    tick();
    b1.load = 1'b0;
    if (b1.at_notch !== 1'b1) begin miss_cnt++; $display("FAIL notch_at got %b want 1", b1.at_notch); end
    vec_cnt++;
    b1.step_in = 1'b1;
    #1;
    if (b1.carry_out !== 1'b1) begin miss_cnt++; $display("FAIL notch_carry got %b want 1", b1.carry_out); end
    vec_cnt++;
    tick();
    for (int p = 17; p <= 25; p++) begin
      if (b1.pos !== 5'(p)) begin miss_cnt++; $display("FAIL notch_walk_pos got %0d want %0d", b1.pos, p); end
      vec_cnt++;
      if (b1.carry_out !== 1'b0) begin miss_cnt++; $display("FAIL notch_walk_carry at %0d got %b want 0", p, b1.carry_out); end
      vec_cnt++;
      tick();
    end
    if (b1.pos !== 5'd0) begin miss_cnt++; $display("FAIL notch_wrap got %0d want 0", b1.pos); end
    vec_cnt++;
    b1.step_in = 1'b0;
  endtask

  task automatic test_double_step();
    b1.load = 1'b1; b1.load_pos = 5'd16;
    b2.load = 1'b1; b2.load_pos = 5'd16;
    tick();
    b1.load = 1'b0;
    b2.load = 1'b0;
    b1.key_step = 1'b1;
    b2.key_step = 1'b1;
    #1;
    if (b2.carry_out !== 1'b1) begin miss_cnt++; $display("FAIL dbl_carry got %b want 1", b2.carry_out); end
    vec_cnt++;
    if (b1.carry_out !== 1'b0) begin miss_cnt++; $display("FAIL nodbl_carry got %b want 0", b1.carry_out); end
    vec_cnt++;
    tick();
    b1.key_step = 1'b0;
    b2.key_step = 1'b0;
    if (b2.pos !== 5'd17) begin miss_cnt++; $display("FAIL dbl_pos got %0d want 17", b2.pos); end
    vec_cnt++;
    if (b1.pos !== 5'd16) begin miss_cnt++; $display("FAIL nodbl_pos got %0d want 16", b1.pos); end
    vec_cnt++;
  endtask

  task automatic test_load_err_reset();
    b1.load = 1'b1;
    b1.load_pos = 5'd26;
    tick();
    b1.load = 1'b0;
    if (b1.pos !== 5'd16) begin miss_cnt++; $display("FAIL lerr_pos got %0d want 16", b1.pos); end
    vec_cnt++;
    if (b1.load_err !== 1'b1) begin miss_cnt++; $display("FAIL lerr_set got %b want 1", b1.load_err); end
    vec_cnt++;
    tick();
    if (b1.load_err !== 1'b0) begin miss_cnt++; $display("FAIL lerr_clear got %b want 0", b1.load_err); end
    vec_cnt++;
    // load beats a simultaneous step
    b1.load = 1'b1;
    b1.load_pos = 5'd5;
    b1.step_in = 1'b1;
    tick();
    b1.load = 1'b0;
    b1.step_in = 1'b0;
    if (b1.pos !== 5'd5) begin miss_cnt++; $display("FAIL load_prio got %0d want 5", b1.pos); end
    vec_cnt++;
    #2;
    reset = 1'b1;
    #1;
    if (b1.pos !== 5'd0) begin miss_cnt++; $display("FAIL async_reset got %0d want 0", b1.pos); end
    vec_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_affine();
    logic [6:0] f;
    logic [6:0] x_vec;
    b3.ring = 3'd0;
    for (int p = 0; p < 7; p++) begin
      b3.load = 1'b1;
      b3.load_pos = 3'(p);
      tick();
      b3.load = 1'b0;
      if (b3.pos !== 3'(p)) begin miss_cnt++; $display("FAIL aff_load got %0d want %0d", b3.pos, p); end
      vec_cnt++;
      for (int x = 0; x < 7; x++) begin
        x_vec = 7'd1 << x;
        b3.fwd_in = x_vec;
        #1;
        f = b3.fwd_out;
        b3.rev_in = f;
        #1;
        if (b3.rev_out !== x_vec) begin
          miss_cnt++; $display("FAIL aff_roundtrip p=%0d x=%0d got %b want %b", p, x, b3.rev_out, x_vec);
        end
        vec_cnt++;
        if ($countones(f) != 1) begin miss_cnt++; $display("FAIL aff_onehot p=%0d x=%0d got %b", p, x, f); end
        vec_cnt++;
        // hand-computed anchors: T[i] = (3i+1) mod 7
        if (x == 0 && p == 0 && f !== 7'b0000010) begin
          miss_cnt++; $display("FAIL aff_p0_x0 got %b want 0000010", f);
        end
        if (x == 0 && p == 0) vec_cnt++;
        if (x == 0 && p == 1 && f !== 7'b0001000) begin
          miss_cnt++; $display("FAIL aff_p1_x0 got %b want 0001000", f);
        end
        if (x == 0 && p == 1) vec_cnt++;
      end
    end
    b3.fwd_in = '0;
    b3.rev_in = '0;
    #1;
    if (b3.fwd_out !== 7'd0) begin miss_cnt++; $display("FAIL aff_zero_fwd got %b want 0", b3.fwd_out); end
    vec_cnt++;
    if (b3.rev_out !== 7'd0) begin miss_cnt++; $display("FAIL aff_zero_rev got %b want 0", b3.rev_out); end
    vec_cnt++;
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    reset = 1'b1;
    b0.load = 1'b0; b0.load_pos = '0; b0.ring = '0; b0.step_in = 1'b0; b0.key_step = 1'b0; b0.fwd_in = '0; b0.rev_in = '0;
    b1.load = 1'b0; b1.load_pos = '0; b1.ring = '0; b1.step_in = 1'b0; b1.key_step = 1'b0; b1.fwd_in = '0; b1.rev_in = '0;
    b2.load = 1'b0; b2.load_pos = '0; b2.ring = '0; b2.step_in = 1'b0; b2.key_step = 1'b0; b2.fwd_in = '0; b2.rev_in = '0;
    b3.load = 1'b0; b3.load_pos = '0; b3.ring = '0; b3.step_in = 1'b0; b3.key_step = 1'b0; b3.fwd_in = '0; b3.rev_in = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    test_reset();
    test_rotor1_pos0();
    test_rotor1_step();
    test_involution();
    test_notch_carry();
    test_double_step();
    test_load_err_reset();
    test_affine();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_param.md
Name: enigma_rotor_param

Overview:
Parametrised, clocked Enigma rotor stage. It is the successor to the fixed 26-letter rotor stage. It applies a selectable wiring permutation to one-hot letter vectors on both the forward (entry->reflector) and reverse (reflector->entry) paths, offset by a registered rotor position and a ring setting. It adds synchronous load, a notch-based carry output for cascading, and optional Enigma double-stepping. Rotors are chained in the datapath between the keyboard encoder and the reflector.

Parameters:
N, 26, alphabet size; width of all one-hot letter vectors (2..32).
W, 5, position/ring width; must satisfy 2**W >= N.
WIRING_SEL, 0, wiring table select (see Behaviour). Values 0-2 are legal only when N=26.
AFF_A, 3, multiplier for affine table (WIRING_SEL=3); gcd(AFF_A,N) must be 1.
AFF_B, 1, offset for affine table (WIRING_SEL=3).
NOTCH, 16, position from which an advance produces carry_out.
DOUBLE_STEP, 0, 1 enables self-advance on key_step while at notch (middle-rotor anomaly).

Ports:
clock      in   1   system clock, rising edge
reset      in   1   asynchronous, active-high; forces pos to 0
load       in   1   synchronous load of load_pos (priority over stepping)
load_pos   in   W   position to load
ring       in   W   ring setting (quasi-static)
step_in    in   1   advance request (keypress for rightmost rotor, neighbour carry_out otherwise)
key_step   in   1   global keypress strobe, used only when DOUBLE_STEP=1
fwd_in     in   N   forward-path one-hot letter
fwd_out    out  N   forward-path permuted letter
rev_in     in   N   reverse-path one-hot letter
rev_out    out  N   reverse-path permuted letter
pos        out  W   current rotor position (registered)
at_notch   out  1   pos == NOTCH
carry_out  out  1   combinational; this rotor advances this cycle from NOTCH
load_err   out  1   registered one-cycle pulse for an out-of-range load

Behaviour:
- Reset (async, active-high): pos=0, load_err=0. Combinational outputs follow from pos=0 immediately.
- Wiring tables T[i], i in 0..N-1, inverse Tinv:
  - Table 0: involution pairs {0,17}{1,20}{2,12}{3,23}{4,9}{5,10}{6,15}{7,18}{8,25}{11,24}{13,16}{14,21}{19,22}.
  - Table 1: "EKMFLGDQVZNTOWYHXUSPAIBRCJ".
  - Table 2: "AJDKSIRUXBLHWTMCQGZNPYFVOE".
  - Table 3: T[i] = (AFF_A*i + AFF_B) mod N.
  - Tables 0-2 are fixed constants. Table 3 is computed at elaboration.
- Offset o = (pos - ring) mod N, computed in W+1 bits, then wrapped.
- Forward path: for each set bit i of fwd_in, set fwd_out bit (T[(i+o) mod N] - o) mod N.
- Reverse path: the same mapping using Tinv. rev_out is the exact inverse of the forward mapping at the same pos.
- Both paths are purely combinational; zero cycles of latency from input to output.
- Inputs that are not one-hot are permuted bitwise: popcount is preserved, and all-zero in gives all-zero out.
- Advance condition: adv = step_in | (DOUBLE_STEP & key_step & at_notch).
- carry_out = adv & at_notch (same cycle, so the whole chain steps on one edge).
- Rising clock edge, in priority order:
  - If load and load_pos < N: pos <= load_pos, load_err <= 0.
  - Else if load and load_pos >= N: pos unchanged, load_err <= 1.
  - Else if adv: pos <= (pos == N-1) ? 0 : pos + 1.
  - Otherwise pos holds and load_err <= 0.
- Load with adv in the same cycle: the load wins, and carry_out is still driven combinationally from adv & at_notch.
- ring >= N is reduced mod N internally.
- Wrap from N-1 to 0 produces no carry unless NOTCH = N-1.
- Reset asserted mid-sequence clears pos regardless of load/step. Deassertion is synchronised by the integrator.

Test Plan:
1. WIRING_SEL=1, reset, ring=0, fwd_in bit 0 -> fwd_out bit 4. Then rev_in bit 4 -> rev_out bit 0.
2. WIRING_SEL=1, one step_in pulse -> pos=1. fwd_in bit 0 -> fwd_out bit 9. rev_in bit 9 -> rev_out bit 0.
3. WIRING_SEL=0, load pos=16 (NOTCH), step_in=1 -> carry_out=1 that cycle, pos=17 next cycle, carry_out=0 on the following step. Repeat to pos=25 then step -> pos=0, no carry.
4. DOUBLE_STEP=1, load pos=16, step_in=0, key_step=1 -> pos advances to 17 with carry_out=1. With DOUBLE_STEP=0 the same stimulus leaves pos=16 and carry_out=0.
5. load_pos=26 with N=26 -> pos unchanged, load_err=1 for exactly one cycle. Then load=1, load_pos=5 with step_in=1 -> pos=5. Assert reset asynchronously between edges -> pos=0 immediately.
6. N=7, WIRING_SEL=3, AFF_A=3, AFF_B=1, sweep every pos and every input bit -> rev_out(fwd_out(x)) = x for all 49 cases. All-zero input -> zero output.
